// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor.
// FSM state encoding and a constant clog2.
package sub_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/digit_subtractor.sv
// DIGIT-bit ripple of 1-bit full-subtractor cells.
// Purely combinational; borrow ripples LSB to MSB.
module digit_subtractor #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             bin,
   output logic [DIGIT-1:0] d,
   output logic             bout
);

   logic [DIGIT:0] bw;

   // ripple borrow through each full-subtractor cell
   always_comb begin
      bw    = '0;
      d     = '0;
      bw[0] = bin;
      for (int i = 0; i < DIGIT; i++) begin
         d[i]    = a[i] ^ b[i] ^ bw[i];
         bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
      end
   end

   assign bout = bw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per clock.
// Valid/ready on both sides; result held until consumed.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             overflow
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CL    = clog2(STEPS);
   localparam int CW    = (CL < 1) ? 1 : CL;

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be >= 2");
   end
   if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
      $error("serial_subtractor: DIGIT out of range");
   end else if ((WIDTH % DIGIT) != 0) begin : g_bad_div
      $error("serial_subtractor: DIGIT must divide WIDTH");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] areg_q;
   logic [WIDTH-1:0] breg_q;
   logic [WIDTH-1:0] dreg_q;
   logic             borrow_q;
   logic             asign_q;
   logic             bsign_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             ovf_q;

   logic [DIGIT-1:0] cell_d;
   logic             cell_b;

   logic [WIDTH+DIGIT-1:0] a_ext;
   logic [WIDTH+DIGIT-1:0] b_ext;
   logic [WIDTH+DIGIT-1:0] d_ext;
   logic [WIDTH-1:0]       areg_d;
   logic [WIDTH-1:0]       breg_d;
   logic [WIDTH-1:0]       dreg_d;
   logic                   last;
   logic                   ovf_d;

   digit_subtractor #(
      .DIGIT (DIGIT)
   ) u_cell (
      .a    (areg_q[DIGIT-1:0]),
      .b    (breg_q[DIGIT-1:0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_b)
   );

   // shift operands right and the new digit into the top of dreg
   always_comb begin
      a_ext  = {{DIGIT{1'b0}}, areg_q};
      b_ext  = {{DIGIT{1'b0}}, breg_q};
      d_ext  = {cell_d, dreg_q};
      areg_d = a_ext[WIDTH+DIGIT-1:DIGIT];
      breg_d = b_ext[WIDTH+DIGIT-1:DIGIT];
      dreg_d = d_ext[WIDTH+DIGIT-1:DIGIT];
      last   = (cnt_q == CW'(STEPS - 1));
      ovf_d  = (asign_q != bsign_q) && (dreg_d[WIDTH-1] != asign_q);
   end

   // control FSM with datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         areg_q      <= '0;
         breg_q      <= '0;
         dreg_q      <= '0;
         borrow_q    <= 1'b0;
         asign_q     <= 1'b0;
         bsign_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  areg_q     <= a;
                  breg_q     <= b;
                  borrow_q   <= bin;
                  asign_q    <= a[WIDTH-1];
                  bsign_q    <= b[WIDTH-1];
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               areg_q   <= areg_d;
               breg_q   <= breg_d;
               dreg_q   <= dreg_d;
               borrow_q <= cell_b;
               cnt_q    <= cnt_q + 1'b1;
               if (last) begin
                  diff_q      <= dreg_d;
                  bout_q      <= cell_b;
                  ovf_q       <= ovf_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor.
// Two instances: 8-bit/1-bit digit and 16-bit/4-bit digit.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        r8_n, iv8, ir8, ov8, or8, bi8, bo8, vf8;
   logic [7:0]  a8, b8, d8;
   logic        r16_n, iv16, ir16, ov16, or16, bi16, bo16, vf16;
   logic [15:0] a16, b16, d16;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_s8 (
      .clk       (clk),
      .rst_n     (r8_n),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .b         (b8),
      .bin       (bi8),
      .out_valid (ov8),
      .out_ready (or8),
      .diff      (d8),
      .bout      (bo8),
      .overflow  (vf8)
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_s16 (
      .clk       (clk),
      .rst_n     (r16_n),
      .in_valid  (iv16),
      .in_ready  (ir16),
      .a         (a16),
      .b         (b16),
      .bin       (bi16),
      .out_valid (ov16),
      .out_ready (or16),
      .diff      (d16),
      .bout      (bo16),
      .overflow  (vf16)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic run8(input string tag,
                       input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] ed,
                       input logic eb, input logic eo,
                       input int hold);
      int n;
      @(negedge clk);
      chk({tag, "_rdy"}, ir8, 1);
      a8 = av; b8 = bv; bi8 = bi; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0; a8 = 8'h5C; b8 = 8'hC5; bi8 = 1'b1;
      chk({tag, "_busy"}, ir8, 0);
      n = 0;
      while (!ov8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_diff"}, d8, ed);
      chk({tag, "_bout"}, bo8, eb);
      chk({tag, "_ovf"}, vf8, eo);
      for (int h = 0; h < hold; h++) begin
         iv8 = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_v"}, ov8, 1);
         chk({tag, "_hold_d"}, d8, ed);
         chk({tag, "_hold_r"}, ir8, 0);
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      chk({tag, "_rel_v"}, ov8, 0);
      chk({tag, "_rel_r"}, ir8, 1);
      chk({tag, "_keep"}, {bo8, vf8, d8}, {eb, eo, ed});
   endtask

   task automatic run16(input string tag,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input logic [15:0] ed,
                        input logic eb, input logic eo);
      int n;
      @(negedge clk);
      chk({tag, "_rdy"}, ir16, 1);
      a16 = av; b16 = bv; bi16 = bi; iv16 = 1'b1;
      @(negedge clk);
      iv16 = 1'b0; a16 = ~av; b16 = ~bv;
      n = 0;
      while (!ov16 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_res"}, {bo16, vf16, d16}, {eb, eo, ed});
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      chk({tag, "_rel"}, {ov16, ir16}, 2'b01);
   endtask

   initial begin
      logic [15:0] ra, rb, rd;
      logic        rbi, rbo, rov;
      logic [16:0] wide;

      r8_n = 1'b0; iv8 = 1'b0; or8 = 1'b0;
      a8 = '0; b8 = '0; bi8 = 1'b0;
      r16_n = 1'b0; iv16 = 1'b0; or16 = 1'b0;
      a16 = '0; b16 = '0; bi16 = 1'b0;
      repeat (2) @(negedge clk);
      r8_n = 1'b1; r16_n = 1'b1;
      chk("rst_rdy", ir8, 1);
      chk("rst_ov", ov8, 0);
      chk("rst_out", {bo8, vf8, d8}, 0);
      chk("rst16", {ir16, ov16, bo16, vf16, d16}, 20'h80000);

      run8("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
      run8("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
      run8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
      run8("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
      run8("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
      run8("t3c", 8'h50, 8'h30, 1'b1, 8'h1F, 1'b0, 1'b0, 0);
      run8("bp", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 3);

      @(negedge clk);
      a8 = 8'h33; b8 = 8'h11; bi8 = 1'b0; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      repeat (3) @(negedge clk);
      r8_n = 1'b0;
      @(negedge clk);
      r8_n = 1'b1;
      chk("mrst_rdy", ir8, 1);
      chk("mrst_ov", ov8, 0);
      chk("mrst_out", {bo8, vf8, d8}, 0);
      run8("t5", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 0);

      run16("t6", 16'h1234, 16'h0FFF, 1'b1, 16'h0234, 1'b0, 1'b0);
      run16("t6b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rbi  = 1'($urandom_range(1, 0));
         wide = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
         rd   = wide[15:0];
         rbo  = wide[16];
         rov  = (ra[15] != rb[15]) && (rd[15] != ra[15]);
         run16("rnd", ra, rb, rbi, rd, rbo, rov);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
